// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: state encoding,
// default widths and the {pc, instr} fetch entry.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_PAUSE = 2'd2,
    FS_ERR   = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory port plus the valid/ready output stream of the fetch unit.
interface fetch_controller_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, out_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register: parks a fetched entry whose memory data would
// otherwise be overwritten while the consumer stalls.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type T = fetch_entry_t
)(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready
);

  logic v;
  T     d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (in_valid && !v) begin
      v <= 1'b1;
      d <= in_data;
    end else if (v && out_ready) begin
      v <= 1'b0;
    end
  end

  assign in_ready  = !v;
  assign out_valid = v;
  assign out_data  = d;

endmodule

// File: rtl/fetch_controller.sv
// Sequential instruction fetch with redirect, enable/drain control and a
// one-entry skid so a stalled consumer never loses the memory's read data.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAST_ADDR = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              addr_err,
  fetch_controller_if.master bus
);

  localparam logic [1:0] ST_IDLE  = FS_IDLE;
  localparam logic [1:0] ST_RUN   = FS_RUN;
  localparam logic [1:0] ST_PAUSE = FS_PAUSE;
  localparam logic [1:0] ST_ERR   = FS_ERR;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight_v;
  logic [ADDR_W-1:0] inflight_pc;
  logic              redir_bad, issue, capture;
  logic              skid_v, skid_rdy;
  entry_t            skid_in, skid_q;

  assign redir_bad = redirect_valid && (redirect_addr > LAST);

  // No issue while the previous fetch is stuck: its data must reach the skid first.
  assign issue = (state == ST_RUN) && enable && !skid_v &&
                 !(inflight_v && !bus.out_ready) && !redirect_valid;

  assign capture = inflight_v && skid_rdy && !bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (redir_bad) begin
      state <= ST_ERR;
    end else if (!redirect_valid) begin
      case (state)
        ST_IDLE:  if (enable)  state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_PAUSE;
        ST_PAUSE: if (enable)  state <= ST_RUN;
        default:               state <= state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
    end else if (redirect_valid && !redir_bad) begin
      fetch_pc <= redirect_addr;
    end else if (issue) begin
      fetch_pc <= (fetch_pc == LAST) ? '0 : fetch_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         addr_err <= 1'b0;
    else if (redir_bad) addr_err <= 1'b1;
  end

  assign skid_in.pc    = inflight_pc;
  assign skid_in.instr = bus.imem_instr;

  fetch_skid_buf #(.T(entry_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (capture),
    .in_data   (skid_in),
    .in_ready  (skid_rdy),
    .out_valid (skid_v),
    .out_data  (skid_q),
    .out_ready (bus.out_ready)
  );

  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = skid_v || inflight_v;

  always_comb begin
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (skid_v) begin
      bus.out_instr = skid_q.instr;
      bus.out_pc    = skid_q.pc;
    end else if (inflight_v) begin
      bus.out_instr = bus.imem_instr;
      bus.out_pc    = inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller with Imem[k] = 0xA0 + k, LAST_ADDR = 4.
module tb_fetch_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = '0;
  logic       addr_err;

  fetch_controller_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  fetch_controller #(.ADDR_W(8), .DATA_W(32), .LAST_ADDR(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .addr_err       (addr_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial bus.imem_instr = '0;
  always @(posedge clk) bus.imem_instr <= 32'h0000_00A0 + {24'h0, bus.imem_addr};

  typedef struct {
    bit       en;
    bit       rv;
    bit [7:0] ra;
    bit       rdy;
    bit       ev;
    bit [7:0] epc;
    bit [7:0] ea;
    bit       ee;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(bit en, bit rv, bit [7:0] ra, bit rdy,
                              bit ev, bit [7:0] epc, bit [7:0] ea, bit ee);
    vec_t v;
    v.en = en; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ea = ea; v.ee = ee;
    return v;
  endfunction

  // {valid, pc, instr, imem_addr, addr_err}
  function automatic logic [49:0] expect_of(bit ev, bit [7:0] epc, bit [7:0] ea, bit ee);
    logic [31:0] ei;
    ei = ev ? (32'h0000_00A0 + {24'h0, epc}) : 32'h0;
    return {ev, (ev ? epc : 8'h0), ei, ea, ee};
  endfunction

  task automatic check(string name, logic [49:0] exp);
    logic [49:0] act;
    act = {bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr, addr_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%b pc=%h instr=%h addr=%h err=%b, want v=%b pc=%h instr=%h addr=%h err=%b",
               name, act[49], act[48:41], act[40:9], act[8:1], act[0],
               exp[49], exp[48:41], exp[40:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic step(string name, vec_t v);
    enable         = v.en;
    redirect_valid = v.rv;
    redirect_addr  = v.ra;
    bus.out_ready  = v.rdy;
    @(posedge clk);
    #1;
    check(name, expect_of(v.ev, v.epc, v.ea, v.ee));
  endtask

  initial begin
    bus.out_ready = 1'b0;

    // Stream, stall, redirect, drain and error sequence from reset release.
    tbl.push_back(mk(1,0,0,1, 0,0,0,0)); // v0  IDLE->RUN
    tbl.push_back(mk(1,0,0,1, 1,0,1,0)); // v1  first valid
    tbl.push_back(mk(1,0,0,1, 1,1,2,0));
    tbl.push_back(mk(1,0,0,1, 1,2,3,0));
    tbl.push_back(mk(1,0,0,1, 1,3,4,0));
    tbl.push_back(mk(1,0,0,1, 1,4,0,0));
    tbl.push_back(mk(1,0,0,1, 1,0,1,0)); // v6  wrap
    tbl.push_back(mk(1,0,0,1, 1,1,2,0));
    tbl.push_back(mk(1,0,0,1, 1,2,3,0)); // v8  pc2 presented
    tbl.push_back(mk(1,0,0,0, 1,2,3,0)); // v9  stall -> skid
    tbl.push_back(mk(1,0,0,0, 1,2,3,0));
    tbl.push_back(mk(1,0,0,0, 1,2,3,0));
    tbl.push_back(mk(1,0,0,1, 0,0,3,0)); // v12 skid drains, bubble
    tbl.push_back(mk(1,0,0,1, 1,3,4,0));
    tbl.push_back(mk(1,0,0,1, 1,4,0,0));
    tbl.push_back(mk(1,0,0,1, 1,0,1,0));
    tbl.push_back(mk(1,0,0,1, 1,1,2,0));
    tbl.push_back(mk(1,0,0,0, 1,1,2,0)); // v17 pc1 into skid
    tbl.push_back(mk(1,1,3,0, 0,0,3,0)); // v18 redirect to 3, flush
    tbl.push_back(mk(1,0,0,1, 1,3,4,0));
    tbl.push_back(mk(1,0,0,1, 1,4,0,0));
    tbl.push_back(mk(1,0,0,1, 1,0,1,0));
    tbl.push_back(mk(1,0,0,1, 1,1,2,0));
    tbl.push_back(mk(1,0,0,1, 1,2,3,0)); // v23 pc2 issued
    tbl.push_back(mk(0,0,0,1, 0,0,3,0)); // v24 enable low, pc2 accepted
    tbl.push_back(mk(0,0,0,1, 0,0,3,0));
    tbl.push_back(mk(1,0,0,1, 0,0,3,0)); // v26 PAUSE->RUN
    tbl.push_back(mk(1,0,0,1, 1,3,4,0));
    tbl.push_back(mk(1,0,0,1, 1,4,0,0));
    tbl.push_back(mk(1,1,9,1, 0,0,0,1)); // v29 bad redirect
    tbl.push_back(mk(1,0,0,1, 0,0,0,1));
    tbl.push_back(mk(1,1,2,1, 0,0,2,1)); // v31 legal redirect in ERR
    tbl.push_back(mk(1,0,0,1, 0,0,2,1));

    #1;
    check("reset_state", expect_of(0, 0, 0, 0));
    @(posedge clk); #1;
    check("reset_held", expect_of(0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Reset leaves ERR and clears the sticky flag.
    rst_n = 1'b0;
    #1;
    check("rst_from_err", expect_of(0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("rs_run",   mk(1,0,0,1, 0,0,0,0));
    step("rs_pc0",   mk(1,0,0,1, 1,0,1,0));
    step("rs_pc1",   mk(1,0,0,1, 1,1,2,0));
    step("rs_stall", mk(1,0,0,0, 1,1,2,0));

    // Asynchronous reset mid-cycle with the skid full.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", expect_of(0, 0, 0, 0));
    @(posedge clk); #1;
    check("async_rst_edge", expect_of(0, 0, 0, 0));
    rst_n = 1'b1;

    step("post_run", mk(1,0,0,1, 0,0,0,0));
    step("post_pc0", mk(1,0,0,1, 1,0,1,0));
    step("post_pc1", mk(1,0,0,1, 1,1,2,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
